// File: rtl/aes_inverse_cipher_pkg.sv
// rtl/aes_inverse_cipher_pkg.sv - shared AES types, inverse S-box, GF(2^8) helpers and inverse round functions
package aes_inverse_cipher_pkg;

  localparam int KEY_SIZE   = 128;
  localparam int NUM_ROUNDS = KEY_SIZE / 32 + 6;

  // byte 0 is the most significant byte; byte r+4c is row r, column c
  typedef logic [0:15][7:0]          state_t;
  typedef state_t                    roundKey_t;
  typedef roundKey_t [0:NUM_ROUNDS]  roundKeys_t;
  typedef logic [3:0]                roundIdx_t;

  // flat 256-entry table; index {hi,lo} nibble equals invSbox[hi][lo]
  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [7:0] gf_xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul9(input logic [7:0] b);
    return gf_xtime(gf_xtime(gf_xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] gf_mul11(input logic [7:0] b);
    return gf_xtime(gf_xtime(gf_xtime(b))) ^ gf_xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] gf_mul13(input logic [7:0] b);
    return gf_xtime(gf_xtime(gf_xtime(b))) ^ gf_xtime(gf_xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] gf_mul14(input logic [7:0] b);
    return gf_xtime(gf_xtime(gf_xtime(b))) ^ gf_xtime(gf_xtime(b)) ^ gf_xtime(b);
  endfunction

  // row r rotates right by r columns
  function automatic state_t InvShiftRows(input state_t s);
    state_t t;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[r + 4*c] = s[r + 4*((c - r + 4) % 4)];
    return t;
  endfunction

  function automatic state_t InvSubBytes(input state_t s);
    state_t t;
    for (int i = 0; i < 16; i++)
      t[i] = INV_SBOX[s[i]];
    return t;
  endfunction

  function automatic state_t InvMixColumns(input state_t s);
    state_t t;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[4*c];
      a1 = s[4*c + 1];
      a2 = s[4*c + 2];
      a3 = s[4*c + 3];
      t[4*c]     = gf_mul14(a0) ^ gf_mul11(a1) ^ gf_mul13(a2) ^ gf_mul9(a3);
      t[4*c + 1] = gf_mul9(a0)  ^ gf_mul14(a1) ^ gf_mul11(a2) ^ gf_mul13(a3);
      t[4*c + 2] = gf_mul13(a0) ^ gf_mul9(a1)  ^ gf_mul14(a2) ^ gf_mul11(a3);
      t[4*c + 3] = gf_mul11(a0) ^ gf_mul13(a1) ^ gf_mul9(a2)  ^ gf_mul14(a3);
    end
    return t;
  endfunction

endpackage

// File: rtl/aes_inverse_cipher_inv_round.sv
// rtl/aes_inverse_cipher_inv_round.sv - one combinational AES inverse round
module aes_inv_round
  import aes_inverse_cipher_pkg::*;
(
  input  state_t    i_state,
  input  roundKey_t i_round_key,
  input  logic      i_is_final,
  output state_t    o_state
);

  state_t w_keyed;

  // the key is added before InvMixColumns; the final round skips the mix
  assign w_keyed = InvSubBytes(InvShiftRows(i_state)) ^ i_round_key;
  assign o_state = i_is_final ? w_keyed : InvMixColumns(w_keyed);

endmodule

// File: rtl/aes_inverse_cipher.sv
// rtl/aes_inverse_cipher.sv - iterative AES inverse cipher, one round per clock
module aes_inverse_cipher
  import aes_inverse_cipher_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  state_t     in_data,
  input  roundKeys_t round_keys,
  output logic       out_valid,
  input  logic       out_ready,
  output state_t     out_data
);

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} fsm_t;

  localparam roundIdx_t LAST_RND = roundIdx_t'(NUM_ROUNDS - 1);

  fsm_t      r_fsm;
  fsm_t      w_fsm_next;
  roundIdx_t r_rnd;
  state_t    r_st;
  state_t    w_round_out;
  logic      w_is_final;

  assign w_is_final = (r_rnd == '0);
  assign out_data   = r_st;

  aes_inv_round u_inv_round (
    .i_state     (r_st),
    .i_round_key (round_keys[r_rnd]),
    .i_is_final  (w_is_final),
    .o_state     (w_round_out)
  );

  // FSM state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_fsm <= S_IDLE;
    else          r_fsm <= w_fsm_next;
  end

  // next state and handshake decode; ready/valid depend on the state only
  always_comb begin
    w_fsm_next = r_fsm;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (r_fsm)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_fsm_next = S_ROUND;
      end
      S_ROUND: begin
        if (w_is_final) w_fsm_next = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_fsm_next = S_IDLE;
      end
      default: w_fsm_next = S_IDLE;
    endcase
  end

  // state and round counter: initial key add on accept, one round per ROUND cycle
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_st  <= '0;
      r_rnd <= '0;
    end else begin
      case (r_fsm)
        S_IDLE: begin
          if (in_valid) begin
            r_st  <= in_data ^ round_keys[NUM_ROUNDS];
            r_rnd <= LAST_RND;
          end
        end
        S_ROUND: begin
          r_st <= w_round_out;
          if (!w_is_final) r_rnd <= r_rnd - 4'd1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_inverse_cipher.sv
// tb/tb_aes_inverse_cipher.sv - scoreboard testbench for aes_inverse_cipher
module tb_aes_inverse_cipher;
  import aes_inverse_cipher_pkg::*;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  logic       clock = 1'b0;
  logic       reset_n;
  logic       in_valid;
  logic       in_ready;
  state_t     in_data;
  roundKeys_t round_keys;
  logic       out_valid;
  logic       out_ready;
  state_t     out_data;

  int n_tests = 0;
  int n_fail  = 0;
  int n_sent  = 0;
  int n_out   = 0;
  int cyc     = 0;
  bit rand_ready = 1'b0;
  logic [127:0] sb_q [$];

  aes_inverse_cipher dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .round_keys (round_keys),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // forward AES-128 key schedule
  function automatic roundKeys_t expand(input logic [127:0] key);
    roundKeys_t ks;
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {SBOX[t[23:16]], SBOX[t[15:8]], SBOX[t[7:0]], SBOX[t[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= NUM_ROUNDS; r++) ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return ks;
  endfunction

  // forward AES cipher used to produce ciphertexts for random plaintexts
  function automatic logic [127:0] encrypt(input logic [127:0] pt, input roundKeys_t ks);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [127:0] x;
    x = pt ^ ks[0];
    for (int i = 0; i < 16; i++) s[i] = x[127 - 8*i -: 8];
    for (int rnd = 1; rnd <= NUM_ROUNDS; rnd++) begin
      for (int i = 0; i < 16; i++) s[i] = SBOX[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[r + 4*c] = s[r + 4*((c + r) % 4)];
      for (int c = 0; c < 4; c++) begin
        if (rnd < NUM_ROUNDS) begin
          s[4*c]   = xt(t[4*c]) ^ xt(t[4*c+1]) ^ t[4*c+1] ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ xt(t[4*c+1]) ^ xt(t[4*c+2]) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ xt(t[4*c+2]) ^ xt(t[4*c+3]) ^ t[4*c+3];
          s[4*c+3] = xt(t[4*c]) ^ t[4*c] ^ t[4*c+1] ^ t[4*c+2] ^ xt(t[4*c+3]);
        end else begin
          for (int r = 0; r < 4; r++) s[4*c+r] = t[4*c+r];
        end
      end
      x = ks[rnd];
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ x[127 - 8*i -: 8];
    end
    for (int i = 0; i < 16; i++) x[127 - 8*i -: 8] = s[i];
    return x;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // monitor: every output handshake pops the scoreboard
  always @(negedge clock) begin
    if (reset_n && out_valid && out_ready) begin
      n_out++;
      n_tests++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: got %h, expected none", out_data);
      end else begin
        logic [127:0] exp;
        exp = sb_q.pop_front();
        if (out_data !== exp) begin
          n_fail++;
          $display("FAIL out_data: got %h, expected %h", out_data, exp);
        end
      end
    end
  end

  always @(posedge clock) begin
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  // waits for IDLE, offers one block, returns the acceptance edge number
  task automatic send(input logic [127:0] key, input logic [127:0] ct, input logic [127:0] pt,
                      input int gap, output int acc);
    int waited = 0;
    do begin
      @(posedge clock); #1;
      waited++;
    end while (!in_ready && waited < 100);
    if (!in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: got in_ready=0, expected 1");
    end
    repeat (gap) begin @(posedge clock); #1; end
    round_keys = expand(key);
    in_data    = ct;
    in_valid   = 1'b1;
    sb_q.push_back(pt);
    n_sent++;
    acc = cyc + 1;
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input int acc, output int lat);
    int k = 0;
    while (!out_valid && k < 100) begin
      @(posedge clock); #1;
      k++;
    end
    lat = cyc - acc;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int acc0, acc1, lat, n_before, k;
    logic [127:0] key, pt;
    reset_n    = 1'b0;
    in_valid   = 1'b1;
    in_data    = C1_CT;
    round_keys = expand(C1_KEY);
    out_ready  = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_int("reset_in_ready", int'(in_ready), 1);
    check_int("reset_out_valid", int'(out_valid), 0);
    check("reset_out_data", out_data, '0);
    in_valid = 1'b0;
    reset_n  = 1'b1;
    @(posedge clock); #1;
    check_int("post_reset_in_ready", int'(in_ready), 1);
    check("post_reset_out_data", out_data, '0);

    // C.1 single block and latency
    out_ready = 1'b1;
    send(C1_KEY, C1_CT, C1_PT, 0, acc0);
    wait_valid(acc0, lat);
    check_int("c1_latency", lat, 10);
    repeat (2) begin @(posedge clock); #1; end

    // App. B then C.1 back to back
    send(B_KEY, B_CT, B_PT, 0, acc0);
    send(C1_KEY, C1_CT, C1_PT, 0, acc1);
    check_int("b2b_spacing", acc1 - acc0, 12);
    wait_valid(acc1, lat);
    check_int("b2b_latency", lat, 10);
    repeat (2) begin @(posedge clock); #1; end

    // backpressure in DONE
    out_ready = 1'b0;
    send(C1_KEY, C1_CT, C1_PT, 0, acc0);
    wait_valid(acc0, lat);
    check_int("bp_latency", lat, 10);
    repeat (5) begin
      @(posedge clock); #1;
      check_int("bp_out_valid", int'(out_valid), 1);
      check("bp_out_data", out_data, C1_PT);
      check_int("bp_in_ready", int'(in_ready), 0);
    end
    n_before  = n_out;
    out_ready = 1'b1;
    @(posedge clock); #1;
    check_int("bp_release_count", n_out - n_before, 1);
    check_int("bp_release_valid", int'(out_valid), 0);
    check_int("bp_release_in_ready", int'(in_ready), 1);

    // in_valid held with junk data while busy
    send(C1_KEY, C1_CT, C1_PT, 0, acc0);
    in_valid = 1'b1;
    k = 0;
    while (!out_valid && k < 100) begin
      in_data = rand128();
      @(posedge clock); #1;
      k++;
    end
    in_valid = 1'b0;
    check_int("busy_latency", cyc - acc0, 10);
    @(posedge clock); #1;
    check_int("busy_idle_after", int'(in_ready), 1);
    check_int("busy_no_dup", n_out, n_sent);
    @(posedge clock); #1;
    check_int("busy_still_idle", int'(out_valid), 0);

    // asynchronous reset while rnd = 5
    send(C1_KEY, C1_CT, C1_PT, 0, acc0);
    repeat (4) begin @(posedge clock); #1; end
    #1;
    reset_n = 1'b0;
    #1;
    check_int("areset_out_valid", int'(out_valid), 0);
    check_int("areset_in_ready", int'(in_ready), 1);
    check("areset_out_data", out_data, '0);
    void'(sb_q.pop_back());
    n_sent--;
    @(posedge clock); #1;
    reset_n = 1'b1;
    send(C1_KEY, C1_CT, C1_PT, 0, acc0);
    wait_valid(acc0, lat);
    check_int("after_reset_latency", lat, 10);
    repeat (2) begin @(posedge clock); #1; end

    // randomized blocks with throttling on both sides
    rand_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      key = rand128();
      pt  = rand128();
      send(key, encrypt(pt, expand(key)), pt, int'($urandom_range(0, 2)), acc0);
    end
    rand_ready = 1'b0;
    @(posedge clock); #1;
    out_ready = 1'b1;
    k = 0;
    while (sb_q.size() != 0 && k < 200) begin
      @(posedge clock); #1;
      k++;
    end
    check_int("final_out_count", n_out, n_sent);
    check_int("final_queue_empty", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_inverse_cipher.md
# aes_inverse_cipher

Iterative AES inverse cipher: accepts one 128-bit ciphertext block plus a precomputed round-key schedule and produces the plaintext block, one round per clock. It is the decrypt-side counterpart to the forward cipher datapath. It consumes the shared `state_t`/`roundKeys_t` types, the inverse S-box and the GF(2^8) ×9/×11/×13/×14 lookups. The key size follows the build-wide `KEY_SIZE`/`NUM_ROUNDS` defines (Nr = 10/12/14).

## Interface
- No parameters; Nr = `NUM_ROUNDS` from the shared definitions.
- `clock` in 1 — single clock; all state on rising edge.
- `reset_n` in 1 — asynchronous assert, active-low; synchronous deassert is the system's responsibility.
- `in_valid` in 1 — ciphertext and keys offered.
- `in_ready` out 1 — block can accept; high only in IDLE.
- `in_data` in `state_t` (128) — ciphertext; byte 0 = MSB = first FIPS-197 hex byte.
- `round_keys` in `roundKeys_t` ((Nr+1)×128) — index 0 = cipher key, index Nr = last round key; must be held stable from acceptance until output handshake.
- `out_valid` out 1 — plaintext available.
- `out_ready` in 1 — downstream accepts.
- `out_data` out `state_t` (128) — plaintext; meaningful only while `out_valid`.

## Operation
- FSM has three states: IDLE, ROUND, DONE.
- IDLE:
  - `in_ready` = 1.
  - On `in_valid && in_ready`: `st <= in_data ^ round_keys[Nr]`, `rnd <= Nr-1`, go to ROUND.
- ROUND, with `rnd` ≥ 1 (middle round):
  - Order: InvShiftRows, InvSubBytes, AddRoundKey(`round_keys[rnd]`), InvMixColumns.
  - `rnd <= rnd-1`.
- ROUND, with `rnd` = 0 (final round):
  - Order: InvShiftRows, InvSubBytes, AddRoundKey(`round_keys[0]`); no InvMixColumns.
  - Go to DONE.
- DONE:
  - `out_valid` = 1; `out_data` = `st`.
  - On `out_ready`: go to IDLE.
- Byte layout: byte s[r+4c] is row r, column c.
- InvShiftRows: new[r+4c] = old[r + 4·((c−r) mod 4)].
- InvSubBytes: b → invSbox[b[7:4]][b[3:0]].
- InvMixColumns, per column (a0..a3):
  - a0' = 14a0^11a1^13a2^9a3
  - a1' = 9a0^14a1^11a2^13a3
  - a2' = 13a0^9a1^14a2^11a3
  - a3' = 11a0^13a1^9a2^14a3
- `rnd` is 4 bits. It never wraps, because the decrement is only taken when `rnd` ≥ 1.
- `in_valid` and `in_data` are ignored outside IDLE. No queuing, no error flag.
- Changes to `round_keys` while busy are not protected against; the result is undefined.

## Timing
- Reset values (while `reset_n` low and immediately after):
  - FSM = IDLE, `rnd` = 0, `st` = 0.
  - `out_valid` = 0, `out_data` = 0.
  - `in_ready` = 1, but no transfer is taken while `reset_n` is low.
- Latency: acceptance edge E0 → `out_valid` high after edge E_Nr (10 cycles for AES-128, 12 for AES-192, 14 for AES-256).
- `in_ready` and `out_valid` are decoded from the FSM register only, with no combinational path from inputs.
- Back-to-back throughput with `out_ready` held high: one block per Nr+2 cycles.
  - The DONE handshake occurs at edge E_Nr+1.
  - The next acceptance occurs at edge E_Nr+2.
- Backpressure: in DONE with `out_ready` = 0, `out_data`/`out_valid` are held indefinitely; `in_ready` stays 0.
- Reset mid-operation (any state): everything returns asynchronously to reset values and the in-flight block is discarded. The first block after reset is processed normally.

## Structure
- Shared package (AESDefinitions) gains `roundIdx_t` (logic [3:0]).
- Shared package also gains helper functions `InvShiftRows`, `InvSubBytes`, `InvMixColumns` operating on `state_t`. These build on the existing GaloisFieldFunctions and SBox tables so a future key-expansion or decrypt pipeline can reuse them.
- The FSM enum stays local to this module.
- One combinational sub-module, `aes_inv_round`:
  - Inputs: `state_t`, `roundKey_t`, `is_final`.
  - Output: next `state_t`.
- The top holds the FSM, `rnd` counter, state register and handshakes.

## Test plan
- FIPS-197 C.1 (AES-128): key 000102…0f schedule, `in_data` 69c4e0d86a7b0430d8cdb78070b4c55a → `out_data` 00112233445566778899aabbccddeeff, `out_valid` exactly 10 cycles after acceptance.
- FIPS-197 App. B followed immediately by C.1 with `out_ready` tied high:
  - App. B: key 2b7e151628aed2a6abf7158809cf4f3c, `in_data` 3925841d02dc09fbdc118597196a0b32 → 3243f6a8885a308d313198a2e0370734.
  - Then C.1 → its plaintext.
  - Acceptance edges exactly 12 cycles apart.
- Backpressure: `out_ready` low for 5 cycles in DONE → `out_valid` = 1 and `out_data` stable every cycle, `in_ready` = 0; completion occurs on the cycle `out_ready` rises.
- Busy-input rejection: drive `in_valid` = 1 with random `in_data` throughout ROUND → no extra acceptance, C.1 result unchanged.
- Async reset when `rnd` = 5: `out_valid` = 0, `in_ready` = 1 without waiting for a clock edge; a subsequent C.1 block decrypts correctly in 10 cycles.
- Randomized: 1,000 blocks against a software reference model, with random `in_valid`/`out_ready` throttling → all outputs match, no drops or duplicates.
